idexe_stage: RTL and testbench

- Pipeline register between decode (ID) and execute (EXE) in the bexkat1 core.
- It is the consumer of the hazard unit's outputs. It applies the hazard1/hazard2 forwarding selects to pick each operand from the register file, the EXE result or the MEM result, then registers the operands.
- It injects a bubble into EXE on a load-use stall or a branch flush, and holds its contents while EXE is halted.
- Saturating counters report stall and flush bubbles for performance monitoring.

---
 rtl/idexe_stage.sv | 169 ++++++++++++++++
 tb/tb_idexe_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idexe_stage.sv
// rtl/idexe_stage.sv - ID/EXE pipeline register with forwarding muxes, bubble injection and bubble counters
module idexe_stage #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [63:0]      id_ir,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [1:0]       id_reg_write,
  input  logic [WIDTH-1:0] id_rd1,
  input  logic [WIDTH-1:0] id_rd2,
  input  logic [1:0]       hazard1,
  input  logic [1:0]       hazard2,
  input  logic [WIDTH-1:0] exe_result,
  input  logic [WIDTH-1:0] mem_result,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             halt_i,
  output logic [63:0]      exe_ir,
  output logic [WIDTH-1:0] exe_pc,
  output logic [1:0]       exe_reg_write,
  output logic [WIDTH-1:0] exe_op1,
  output logic [WIDTH-1:0] exe_op2,
  output logic             flush_pending,
  output logic [CNTW-1:0]  stall_count,
  output logic [CNTW-1:0]  flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HOLD       = 2'd1,
    HOLD_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      ir_q, ir_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [1:0]       rw_q, rw_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             pend_q, pend_d;
  logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0]  flush_cnt_q, flush_cnt_d;

  logic [WIDTH-1:0] fwd_op1, fwd_op2;
  logic             do_load, do_bubble, inc_stall, inc_flush;

  // Forwarding muxes: 1 takes the MEM result, 2 the EXE result, 0 and 3 the register file
  always_comb begin
    fwd_op1 = id_rd1;
    fwd_op2 = id_rd2;
    case (hazard1)
      2'd1:    fwd_op1 = mem_result;
      2'd2:    fwd_op1 = exe_result;
      default: fwd_op1 = id_rd1;
    endcase
    case (hazard2)
      2'd1:    fwd_op2 = mem_result;
      2'd2:    fwd_op2 = exe_result;
      default: fwd_op2 = id_rd2;
    endcase
  end

  // Next-state and next-register computation; halt holds everything, a latched flush wins on release
  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_bubble = 1'b0;
    inc_stall = 1'b0;
    inc_flush = 1'b0;

    case (state_q)
      RUN, HOLD: begin
        if (halt_i) begin
          if (flush_i) begin
            state_d = HOLD_FLUSH;
          end else if (state_q == RUN) begin
            state_d = HOLD;
          end
        end else begin
          state_d = RUN;
          if (flush_i) begin
            do_bubble = 1'b1;
            inc_flush = 1'b1;
          end else if (stall_i) begin
            do_bubble = 1'b1;
            inc_stall = 1'b1;
          end else begin
            do_load = 1'b1;
          end
        end
      end
      HOLD_FLUSH: begin
        if (!halt_i) begin
          state_d   = RUN;
          do_bubble = 1'b1;
          inc_flush = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    ir_d  = ir_q;
    pc_d  = pc_q;
    rw_d  = rw_q;
    op1_d = op1_q;
    op2_d = op2_q;
    if (do_bubble) begin
      ir_d  = '0;
      pc_d  = '0;
      rw_d  = '0;
      op1_d = '0;
      op2_d = '0;
    end else if (do_load) begin
      ir_d  = id_ir;
      pc_d  = id_pc;
      rw_d  = id_reg_write;
      op1_d = fwd_op1;
      op2_d = fwd_op2;
    end

    pend_d = (state_d == HOLD_FLUSH);

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (inc_stall && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (inc_flush && (flush_cnt_q != {CNTW{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State, pipeline and counter registers; reset discards any pending flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      ir_q        <= '0;
      pc_q        <= '0;
      rw_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc_q        <= pc_d;
      rw_q        <= rw_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign exe_ir        = ir_q;
  assign exe_pc        = pc_q;
  assign exe_reg_write = rw_q;
  assign exe_op1       = op1_q;
  assign exe_op2       = op2_q;
  assign flush_pending = pend_q;
  assign stall_count   = stall_cnt_q;
  assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_idexe_stage.sv
// tb/tb_idexe_stage.sv - self-checking bench for idexe_stage
module tb_idexe_stage;
  localparam int W  = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [63:0]   id_ir;
  logic [W-1:0]  id_pc;
  logic [1:0]    id_reg_write;
  logic [W-1:0]  id_rd1, id_rd2;
  logic [1:0]    hazard1, hazard2;
  logic [W-1:0]  exe_result, mem_result;
  logic          stall_i, flush_i, halt_i;
  logic [63:0]   exe_ir;
  logic [W-1:0]  exe_pc;
  logic [1:0]    exe_reg_write;
  logic [W-1:0]  exe_op1, exe_op2;
  logic          flush_pending;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk_i = ~clk_i;

  idexe_stage #(.WIDTH(W), .CNTW(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_ir(id_ir), .id_pc(id_pc), .id_reg_write(id_reg_write),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .hazard1(hazard1), .hazard2(hazard2),
    .exe_result(exe_result), .mem_result(mem_result),
    .stall_i(stall_i), .flush_i(flush_i), .halt_i(halt_i),
    .exe_ir(exe_ir), .exe_pc(exe_pc), .exe_reg_write(exe_reg_write),
    .exe_op1(exe_op1), .exe_op2(exe_op2),
    .flush_pending(flush_pending),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what EXE should see, whether a flush is owed, and bubble tallies
  logic [63:0]  m_ir;
  logic [W-1:0] m_pc, m_op1, m_op2;
  logic [1:0]   m_rw;
  bit           m_pend;
  int           m_sc, m_fc;

  typedef struct {
    logic [1:0]   h1;
    logic [1:0]   h2;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
  } fwd_vec_t;

  fwd_vec_t fwd_tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] rd,
                                         input logic [W-1:0] ex, input logic [W-1:0] mem);
    if (s == 2'd1) return mem;
    if (s == 2'd2) return ex;
    return rd;
  endfunction

  task automatic model_clear();
    m_ir = '0; m_pc = '0; m_rw = '0; m_op1 = '0; m_op2 = '0;
    m_pend = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_bubble();
    m_ir = '0; m_pc = '0; m_rw = '0; m_op1 = '0; m_op2 = '0;
  endtask

  task automatic model_edge();
    if (halt_i) begin
      if (flush_i) m_pend = 1;
    end else if (m_pend || flush_i) begin
      model_bubble();
      if (m_fc < CMAX) m_fc++;
      m_pend = 0;
    end else if (stall_i) begin
      model_bubble();
      if (m_sc < CMAX) m_sc++;
    end else begin
      m_ir  = id_ir;
      m_pc  = id_pc;
      m_rw  = id_reg_write;
      m_op1 = pick(hazard1, id_rd1, exe_result, mem_result);
      m_op2 = pick(hazard2, id_rd2, exe_result, mem_result);
    end
  endtask

  task automatic cmp_all();
    chk("exe_ir", exe_ir, m_ir);
    chk("exe_pc", 64'(exe_pc), 64'(m_pc));
    chk("exe_reg_write", 64'(exe_reg_write), 64'(m_rw));
    chk("exe_op1", 64'(exe_op1), 64'(m_op1));
    chk("exe_op2", 64'(exe_op2), 64'(m_op2));
    chk("flush_pending", 64'(flush_pending), 64'(m_pend));
    chk("stall_count", 64'(stall_count), 64'(m_sc));
    chk("flush_count", 64'(flush_count), 64'(m_fc));
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    cmp_all();
  endtask

  task automatic idle_inputs();
    id_ir = '0; id_pc = '0; id_reg_write = '0;
    id_rd1 = '0; id_rd2 = '0; hazard1 = '0; hazard2 = '0;
    exe_result = '0; mem_result = '0;
    stall_i = 0; flush_i = 0; halt_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1;
    #1;
    model_clear();
    cmp_all();
    @(negedge clk_i);
    rst_i = 0;
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk_i);
    chk("reset_exe_ir", exe_ir, 64'h0);
    chk("reset_pending", 64'(flush_pending), 64'h0);
    cmp_all();
    rst_i = 0;

    // Forwarding table
    fwd_tbl[0] = '{2'd0, 2'd0, 32'h11, 32'h44};
    fwd_tbl[1] = '{2'd1, 2'd0, 32'h33, 32'h44};
    fwd_tbl[2] = '{2'd2, 2'd0, 32'h22, 32'h44};
    fwd_tbl[3] = '{2'd3, 2'd0, 32'h11, 32'h44};
    fwd_tbl[4] = '{2'd0, 2'd0, 32'h11, 32'h44};
    fwd_tbl[5] = '{2'd0, 2'd1, 32'h11, 32'h33};
    fwd_tbl[6] = '{2'd0, 2'd2, 32'h11, 32'h22};
    fwd_tbl[7] = '{2'd0, 2'd3, 32'h11, 32'h44};
    id_rd1 = 32'h11; id_rd2 = 32'h44; exe_result = 32'h22; mem_result = 32'h33;
    id_ir = 64'h1; id_pc = 32'h100; id_reg_write = 2'b01;
    for (int i = 0; i < 8; i++) begin
      hazard1 = fwd_tbl[i].h1;
      hazard2 = fwd_tbl[i].h2;
      step();
      chk($sformatf("fwd_op1[%0d]", i), 64'(exe_op1), 64'(fwd_tbl[i].e1));
      chk($sformatf("fwd_op2[%0d]", i), 64'(exe_op2), 64'(fwd_tbl[i].e2));
    end

    // Load-use stall then load
    idle_inputs();
    do_reset();
    id_ir = 64'h0000_0000_7012_3000; id_pc = 32'h40; id_reg_write = 2'b11;
    stall_i = 1;
    step();
    chk("stall_ir", exe_ir, 64'h0);
    chk("stall_rw", 64'(exe_reg_write), 64'h0);
    chk("stall_cnt", 64'(stall_count), 64'h1);
    stall_i = 0;
    step();
    chk("after_stall_ir", exe_ir, 64'h0000_0000_7012_3000);
    chk("after_stall_rw", 64'(exe_reg_write), 64'h3);

    // Halt for 3 cycles with flush pulsed in cycle 2
    id_ir = 64'hDEAD; id_pc = 32'h44;
    halt_i = 1;
    step();
    flush_i = 1;
    step();
    flush_i = 0;
    step();
    chk("halt_hold_ir", exe_ir, 64'h0000_0000_7012_3000);
    chk("halt_pending", 64'(flush_pending), 64'h1);
    halt_i = 0;
    step();
    chk("release_bubble_ir", exe_ir, 64'h0);
    chk("release_flush_cnt", 64'(flush_count), 64'h1);
    chk("release_pending", 64'(flush_pending), 64'h0);
    step();
    chk("resume_ir", exe_ir, 64'hDEAD);

    // Flush and stall together
    flush_i = 1; stall_i = 1;
    step();
    chk("fs_ir", exe_ir, 64'h0);
    chk("fs_flush_cnt", 64'(flush_count), 64'h2);
    chk("fs_stall_cnt", 64'(stall_count), 64'h1);
    flush_i = 0; stall_i = 0;

    // Saturation of the stall counter
    stall_i = 1;
    for (int i = 0; i < CMAX + 4; i++) step();
    chk("stall_saturate", 64'(stall_count), 64'(CMAX));
    stall_i = 0;

    // Async reset while a flush is pending
    halt_i = 1; flush_i = 1;
    step();
    flush_i = 0;
    step();
    chk("pre_reset_pending", 64'(flush_pending), 64'h1);
    @(negedge clk_i);
    rst_i = 1;
    #1;
    model_clear();
    chk("async_rst_pending", 64'(flush_pending), 64'h0);
    chk("async_rst_count", 64'(stall_count), 64'h0);
    cmp_all();
    @(negedge clk_i);
    rst_i = 0;
    halt_i = 0;
    id_ir = 64'h1234_5678_9ABC_DEF0; id_pc = 32'h80;
    step();
    chk("post_reset_load", exe_ir, 64'h1234_5678_9ABC_DEF0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      id_ir        = {$urandom, $urandom};
      id_pc        = $urandom;
      id_reg_write = 2'($urandom_range(0, 3));
      id_rd1       = $urandom;
      id_rd2       = $urandom;
      exe_result   = $urandom;
      mem_result   = $urandom;
      hazard1      = 2'($urandom_range(0, 3));
      hazard2      = 2'($urandom_range(0, 3));
      halt_i       = ($urandom_range(0, 3) == 0);
      flush_i      = ($urandom_range(0, 5) == 0);
      stall_i      = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
